// File: rtl/ascii_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : ascii_cmd_parser
//  Purpose  : Decodes a stream of ASCII characters into plotter commands made
//             of an op letter ('f' or 'r'), 1..MAX_DIGITS decimal digits and
//             a CR/LF terminator.
//  Revision : 1.0 - initial release
// ============================================================================
module ascii_cmd_parser #(
    parameter int MAX_DIGITS = 4,
    parameter int ARG_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_op,
    output logic [ARG_W-1:0] cmd_arg,
    output logic             err,
    output logic [7:0]       last_char
);

    localparam int                 c_CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        HOLD   = 2'd2,
        SKIP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_op;
    logic               w_op_nxt;
    logic [ARG_W-1:0]   r_arg;
    logic [ARG_W-1:0]   w_arg_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [7:0]         r_last_char;
    logic [7:0]         w_last_nxt;

    logic               w_accept;
    logic               w_is_digit;
    logic               w_is_term;
    logic               w_is_op;
    logic [ARG_W-1:0]   w_digit;
    logic [ARG_W-1:0]   w_arg_x10;

    assign in_ready  = !rst && (r_state != HOLD);
    assign w_accept  = in_valid && in_ready;

    assign w_is_digit = (in_data >= 8'd48) && (in_data <= 8'd57);
    assign w_is_term  = (in_data == 8'd10) || (in_data == 8'd13);
    assign w_is_op    = (in_data == 8'd102) || (in_data == 8'd114);

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
    assign w_digit   = {{(ARG_W-4){1'b0}}, in_data[3:0]};
    assign w_arg_x10 = (r_arg << 3) + (r_arg << 1);

    assign cmd_valid = (r_state == HOLD);
    assign cmd_op    = r_op;
    assign cmd_arg   = r_arg;
    assign err       = r_err;
    assign last_char = r_last_char;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_arg_nxt   = r_arg;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_last_nxt  = r_last_char;

        if (w_accept) begin
            w_last_nxt = in_data;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_op) begin
                        w_state_nxt = DIGITS;
                        w_op_nxt    = (in_data == 8'd114);
                        w_arg_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (!w_is_term) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = SKIP;
                    end
                end
            end
            DIGITS: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        if (r_cnt < c_MAX_CNT) begin
                            w_arg_nxt = w_arg_x10 + w_digit;
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = SKIP;
                        end
                    end else if (w_is_term) begin
                        if (r_cnt != '0) begin
                            w_state_nxt = HOLD;
                        end else begin
                            // Terminator is consumed, so the next line starts clean
                            w_err_nxt   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = SKIP;
                    end
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            SKIP: begin
                if (w_accept && w_is_term) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= 1'b0;
            r_arg       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_last_char <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_arg       <= w_arg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_last_char <= w_last_nxt;
        end
    end

endmodule
`default_nettype wire
